// File: rtl/c1541_trkbuf_arb.sv
`default_nettype none
// ============================================================================
//  Module      : c1541_trkbuf_arb
//  Description : Arbiter sharing one single-port byte-wide track-buffer RAM
//                between drive 0, drive 1 and the SD sector loader.
//                Drives beat SD; drives alternate round-robin. Fixed 4-state
//                req/ack pipeline. Optional SD anti-starvation guard enabled
//                by defining TRKBUF_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module c1541_trkbuf_arb #(
    parameter int AW         = 13,
    parameter int STARVE_MAX = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d0_req,
    input  logic          d0_we,
    input  logic [AW-1:0] d0_addr,
    input  logic [7:0]    d0_wdata,
    output logic          d0_ack,
    output logic [7:0]    d0_rdata,
    input  logic          d1_req,
    input  logic          d1_we,
    input  logic [AW-1:0] d1_addr,
    input  logic [7:0]    d1_wdata,
    output logic          d1_ack,
    output logic [7:0]    d1_rdata,
    input  logic          sd_req,
    input  logic          sd_we,
    input  logic [AW-1:0] sd_addr,
    input  logic [7:0]    sd_wdata,
    output logic          sd_ack,
    output logic [7:0]    sd_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_q,
    output logic          busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_ACK   = 2'd3;

    localparam logic [1:0] c_OWN_D0 = 2'd0;
    localparam logic [1:0] c_OWN_D1 = 2'd1;
    localparam logic [1:0] c_OWN_SD = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [1:0]    r_owner;
    logic          r_rr_last;
    logic [AW-1:0] r_ram_addr;
    logic [7:0]    r_ram_wdata;
    logic          r_ram_we;
    logic [7:0]    r_d0_rdata;
    logic [7:0]    r_d1_rdata;
    logic [7:0]    r_sd_rdata;

    logic          w_any_req;
    logic          w_arb;
    logic          w_sd_prio;
    logic [1:0]    w_gnt_owner;
    logic [AW-1:0] w_gnt_addr;
    logic [7:0]    w_gnt_wdata;
    logic          w_gnt_we;

    assign w_any_req = d0_req | d1_req | sd_req;
    assign w_arb     = (r_state == c_ST_IDLE) && w_any_req;

`ifdef TRKBUF_STARVE_GUARD_EN
    localparam int              c_CW         = $clog2(STARVE_MAX + 1);
    localparam logic [c_CW-1:0] c_STARVE_MAX = c_CW'(STARVE_MAX);

    logic [c_CW-1:0] r_starve_cnt;
    logic            w_sd_waiting;

    // SD is "waiting" whenever it asks and is not the one being served.
    assign w_sd_waiting = sd_req && !((r_state != c_ST_IDLE) && (r_owner == c_OWN_SD));
    assign w_sd_prio    = sd_req && (r_starve_cnt == c_STARVE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_arb && (w_gnt_owner == c_OWN_SD)) begin
            r_starve_cnt <= '0;
        end else if (w_sd_waiting && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    logic w_unused_starve;

    assign w_sd_prio       = 1'b0;
    assign w_unused_starve = (STARVE_MAX > 0);
`endif

    // Winner selection; r_rr_last==1 means drive 1 was served last.
    always_comb begin
        w_gnt_owner = c_OWN_D0;
        if (w_sd_prio) begin
            w_gnt_owner = c_OWN_SD;
        end else if (d0_req && d1_req) begin
            w_gnt_owner = r_rr_last ? c_OWN_D0 : c_OWN_D1;
        end else if (d0_req) begin
            w_gnt_owner = c_OWN_D0;
        end else if (d1_req) begin
            w_gnt_owner = c_OWN_D1;
        end else if (sd_req) begin
            w_gnt_owner = c_OWN_SD;
        end
    end

    always_comb begin
        w_gnt_addr  = d0_addr;
        w_gnt_wdata = d0_wdata;
        w_gnt_we    = d0_we;
        case (w_gnt_owner)
            c_OWN_D1: begin
                w_gnt_addr  = d1_addr;
                w_gnt_wdata = d1_wdata;
                w_gnt_we    = d1_we;
            end
            c_OWN_SD: begin
                w_gnt_addr  = sd_addr;
                w_gnt_wdata = sd_wdata;
                w_gnt_we    = sd_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_any_req) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_READ;
            c_ST_READ:  w_state_nxt = c_ST_ACK;
            c_ST_ACK:   w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        d0_ack = (r_state == c_ST_ACK) && (r_owner == c_OWN_D0);
        d1_ack = (r_state == c_ST_ACK) && (r_owner == c_OWN_D1);
        sd_ack = (r_state == c_ST_ACK) && (r_owner == c_OWN_SD);
        busy   = (r_state != c_ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner     <= c_OWN_D0;
            r_rr_last   <= 1'b1;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_d0_rdata  <= '0;
            r_d1_rdata  <= '0;
            r_sd_rdata  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner     <= w_gnt_owner;
                        r_ram_addr  <= w_gnt_addr;
                        r_ram_wdata <= w_gnt_wdata;
                        r_ram_we    <= w_gnt_we;
                        if (w_gnt_owner != c_OWN_SD) begin
                            r_rr_last <= (w_gnt_owner == c_OWN_D1);
                        end
                    end
                end
                c_ST_ISSUE: r_ram_we <= 1'b0;
                // Writes also capture ram_q, which returns the written byte.
                c_ST_READ: begin
                    case (r_owner)
                        c_OWN_D0: r_d0_rdata <= ram_q;
                        c_OWN_D1: r_d1_rdata <= ram_q;
                        c_OWN_SD: r_sd_rdata <= ram_q;
                        default:  ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign d0_rdata  = r_d0_rdata;
    assign d1_rdata  = r_d1_rdata;
    assign sd_rdata  = r_sd_rdata;

endmodule
`default_nettype wire
